// File: rtl/mode_display_ctrl_pkg.sv
// Shared definitions for the watch display sequencer: mode encodings, LED bit map,
// default timing constants and counter-width helpers.
package mode_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLOCK     = 2'd0,
    ST_STOPWATCH = 2'd1,
    ST_ALARM     = 2'd2,
    ST_RING      = 2'd3
  } mode_t;

  localparam int DEF_DEB_CYCLES   = 20;
  localparam int DEF_RING_CYCLES  = 30000;
  localparam int DEF_BLANK_CYCLES = 2;
  localparam int DEF_BLINK_HALF   = 250;

  localparam int LED_CLOCK     = 0;
  localparam int LED_STOPWATCH = 1;
  localparam int LED_ALARM     = 2;
  localparam int LED_RING      = 7;

  localparam logic [7:0] SEG_DATA_OFF = 8'h00;
  localparam logic [7:0] SEG_COM_OFF  = 8'hFF;

  // A counter for n states never needs fewer than one bit.
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] ledMap(input mode_t s);
    logic [7:0] v;
    v = '0;
    case (s)
      ST_CLOCK:     v[LED_CLOCK]     = 1'b1;
      ST_STOPWATCH: v[LED_STOPWATCH] = 1'b1;
      ST_ALARM:     v[LED_ALARM]     = 1'b1;
      default:      v[LED_RING]      = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mode_display_ctrl_if.sv
// Display bus between the watch/stopwatch/alarm requesters and the shared 7-segment pins.
interface mode_display_ctrl_if;
  logic [7:0] clk_seg_data;
  logic [7:0] clk_seg_com;
  logic [7:0] sw_seg_data;
  logic [7:0] sw_seg_com;
  logic [7:0] al_seg_data;
  logic [7:0] al_seg_com;
  logic [7:0] seg_data;
  logic [7:0] seg_com;

  modport master (
    output clk_seg_data, clk_seg_com, sw_seg_data, sw_seg_com, al_seg_data, al_seg_com,
    input  seg_data, seg_com
  );

  modport slave (
    input  clk_seg_data, clk_seg_com, sw_seg_data, sw_seg_com, al_seg_data, al_seg_com,
    output seg_data, seg_com
  );
endinterface

// File: rtl/mode_display_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter and a one-cycle press pulse
// on each accepted 0->1 transition of the debounced level.
module mode_display_ctrl_debounce
  import mode_display_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cntWidth(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_stableCnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync[1] != r_level);
  assign w_accept  = w_differs && (r_stableCnt == CNT_LAST);
  assign o_press   = w_accept && r_sync[1];

  // Any sample equal to the current level restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_level     <= 1'b0;
      r_stableCnt <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (!w_differs) begin
        r_stableCnt <= '0;
      end else if (w_accept) begin
        r_level     <= r_sync[1];
        r_stableCnt <= '0;
      end else begin
        r_stableCnt <= r_stableCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mode_display_ctrl.sv
// Mode sequencer and display arbiter: debounced mode/ack buttons, CLOCK/STOPWATCH/ALARM
// cycling with alarm-ring preemption, and a registered, blanked and blinking display mux.
module mode_display_ctrl
  import mode_display_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int RING_CYCLES  = DEF_RING_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_mode_btn,
  input  logic                      i_ack_btn,
  input  logic                      i_alarm_match,
  mode_display_ctrl_if.slave        seg_if,
  output logic [1:0]                o_mode_sel,
  output logic                      o_ringing,
  output logic                      o_mode_chg,
  output logic [7:0]                o_led
);

  localparam int RCW = cntWidth(RING_CYCLES);
  localparam int BCW = cntWidth(2 * BLINK_HALF);
  localparam int KCW = cntWidth(BLANK_CYCLES);
  localparam logic [RCW-1:0] RING_LAST  = RCW'(RING_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(2 * BLINK_HALF - 1);
  localparam logic [BCW-1:0] BLINK_ON   = BCW'(BLINK_HALF);
  localparam logic [KCW-1:0] BLANK_LOAD = KCW'(BLANK_CYCLES - 1);

  mode_t          r_state, r_saved, w_nextState, w_nextSaved;
  logic [RCW-1:0] r_ringCnt;
  logic [BCW-1:0] r_blinkCnt, w_blinkAdv;
  logic [KCW-1:0] r_blankCnt;
  logic           r_modeChg, r_ringing;
  logic [7:0]     r_led, r_segData, r_segCom;
  logic [7:0]     w_srcData, w_srcCom, w_showData, w_showCom;
  logic           w_modePress, w_ackPress, w_ringRestart, w_stateChg, w_blank, w_blinkOn;

  mode_display_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_modeDebounce (
    .clk(clk), .rst(rst), .i_btn(i_mode_btn), .o_press(w_modePress)
  );

  mode_display_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ackDebounce (
    .clk(clk), .rst(rst), .i_btn(i_ack_btn), .o_press(w_ackPress)
  );

  // An alarm always outranks a mode press; in RING a repeated alarm only restarts the timeout.
  always_comb begin
    w_nextState   = r_state;
    w_nextSaved   = r_saved;
    w_ringRestart = 1'b0;
    if (r_state == ST_RING) begin
      if (i_alarm_match) begin
        w_ringRestart = 1'b1;
      end else if (w_ackPress || (r_ringCnt == RING_LAST)) begin
        w_nextState = r_saved;
      end
    end else if (i_alarm_match) begin
      w_nextState = ST_RING;
      w_nextSaved = r_state;
    end else if (w_modePress) begin
      case (r_state)
        ST_CLOCK:     w_nextState = ST_STOPWATCH;
        ST_STOPWATCH: w_nextState = ST_ALARM;
        default:      w_nextState = ST_CLOCK;
      endcase
    end
  end

  assign w_stateChg = (w_nextState != r_state);
  assign w_blinkAdv = (r_blinkCnt == BLINK_LAST) ? '0 : r_blinkCnt + BCW'(1);
  assign w_blinkOn  = (w_blinkAdv < BLINK_ON);
  assign w_blank    = r_modeChg || (r_blankCnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLOCK;
      r_saved    <= ST_CLOCK;
      r_modeChg  <= 1'b0;
      r_ringing  <= 1'b0;
      r_led      <= ledMap(ST_CLOCK);
      r_ringCnt  <= '0;
      r_blinkCnt <= '0;
      r_blankCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_saved   <= w_nextSaved;
      r_modeChg <= w_stateChg;
      r_ringing <= (w_nextState == ST_RING);
      r_led     <= ledMap(w_nextState);
      if ((w_nextState != ST_RING) || w_stateChg || w_ringRestart) begin
        r_ringCnt <= '0;
      end else if (r_ringCnt != RING_LAST) begin
        r_ringCnt <= r_ringCnt + RCW'(1);
      end
      if ((w_nextState != ST_RING) || w_stateChg) begin
        r_blinkCnt <= '0;
      end else begin
        r_blinkCnt <= w_blinkAdv;
      end
      if (r_modeChg) begin
        r_blankCnt <= BLANK_LOAD;
      end else if (r_blankCnt != '0) begin
        r_blankCnt <= r_blankCnt - KCW'(1);
      end
    end
  end

  // RING shows the watch face; the blink phase is evaluated for the cycle being registered.
  always_comb begin
    w_srcData = seg_if.clk_seg_data;
    w_srcCom  = seg_if.clk_seg_com;
    case (r_state)
      ST_STOPWATCH: begin
        w_srcData = seg_if.sw_seg_data;
        w_srcCom  = seg_if.sw_seg_com;
      end
      ST_ALARM: begin
        w_srcData = seg_if.al_seg_data;
        w_srcCom  = seg_if.al_seg_com;
      end
      default: ;
    endcase
    w_showData = w_srcData;
    w_showCom  = w_srcCom;
    if (w_blank || ((r_state == ST_RING) && !w_blinkOn)) begin
      w_showData = SEG_DATA_OFF;
      w_showCom  = SEG_COM_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segData <= SEG_DATA_OFF;
      r_segCom  <= SEG_COM_OFF;
    end else begin
      r_segData <= w_showData;
      r_segCom  <= w_showCom;
    end
  end

  assign seg_if.seg_data = r_segData;
  assign seg_if.seg_com  = r_segCom;
  assign o_mode_sel      = r_state;
  assign o_ringing       = r_ringing;
  assign o_mode_chg      = r_modeChg;
  assign o_led           = r_led;

endmodule
